// File: rtl/fft_bfly_pipe.sv
// Radix-2 DIT butterfly (3-multiplier twiddle form). Latency is 4 cycles at one butterfly per cycle.
// There is no backpressure: every accepted in_valid yields one out_valid, and done pulses on the last result of each N/2 pass.
module fft_bfly_pipe #(
   parameter int N       = 16,
   parameter int DW      = 16,
   parameter int MSB     = 16,
   parameter int TW_W    = 9,
   parameter int TW_FRAC = 7,
   parameter int SCALE   = 1,
   localparam int AW     = $clog2(N/2)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [AW-1:0]         in_addr,
   input  logic signed [DW-1:0]  x0_re,
   input  logic signed [DW-1:0]  x0_im,
   input  logic signed [DW-1:0]  x1_re,
   input  logic signed [DW-1:0]  x1_im,
   input  logic [MSB-1:0]        c_in,
   input  logic [MSB-1:0]        cps_in,
   input  logic [MSB-1:0]        cms_in,
   output logic                  out_valid,
   output logic [AW-1:0]         out_addr,
   output logic signed [DW-1:0]  y0_re,
   output logic signed [DW-1:0]  y0_im,
   output logic signed [DW-1:0]  y1_re,
   output logic signed [DW-1:0]  y1_im,
   output logic                  done
);

   localparam int PW = DW + TW_W + 1;
   localparam int SW = PW + 1;
   localparam int WW = DW + 1;
   localparam int BW = DW + 2;
   localparam logic [AW-1:0] LAST = AW'(N/2 - 1);

   logic                 r1_vld, r2_vld, r3_vld;
   logic [AW-1:0]        r1_addr, r2_addr, r3_addr;
   logic signed [DW-1:0] r1_x0_re, r1_x0_im, r1_a, r1_b;
   logic signed [TW_W-1:0] r1_c, r1_p, r1_m;
   logic signed [DW-1:0] r2_x0_re, r2_x0_im, r3_x0_re, r3_x0_im;
   logic signed [PW-1:0] r2_t, r2_pr, r2_pi;
   logic signed [WW-1:0] r3_wr, r3_wi;
   logic [AW-1:0]        r_cnt;

   logic signed [WW-1:0] w_d;
   logic signed [PW-1:0] w_d_x, w_a_x, w_b_x, w_c_x, w_p_x, w_m_x;
   logic signed [SW-1:0] w_re_sum, w_im_sum, w_re_sh, w_im_sh;
   logic signed [BW-1:0] w_sr0, w_si0, w_sr1, w_si1;
   logic signed [DW-1:0] w_y0_re, w_y0_im, w_y1_re, w_y1_im;
   logic                 w_unused;

   assign w_d   = WW'(r1_a) - WW'(r1_b);
   assign w_d_x = PW'(w_d);
   assign w_a_x = PW'(r1_a);
   assign w_b_x = PW'(r1_b);
   assign w_c_x = PW'(r1_c);
   assign w_p_x = PW'(r1_p);
   assign w_m_x = PW'(r1_m);

   // Products are shifted before truncating to WW bits, so rounding is always toward minus infinity.
   assign w_re_sum = SW'(r2_t) + SW'(r2_pr);
   assign w_im_sum = SW'(r2_pi) - SW'(r2_t);
   assign w_re_sh  = w_re_sum >>> TW_FRAC;
   assign w_im_sh  = w_im_sum >>> TW_FRAC;

   assign w_sr0 = BW'(r3_x0_re) + BW'(r3_wr);
   assign w_si0 = BW'(r3_x0_im) + BW'(r3_wi);
   assign w_sr1 = BW'(r3_x0_re) - BW'(r3_wr);
   assign w_si1 = BW'(r3_x0_im) - BW'(r3_wi);

   assign w_y0_re = (SCALE != 0) ? w_sr0[DW:1] : w_sr0[DW-1:0];
   assign w_y0_im = (SCALE != 0) ? w_si0[DW:1] : w_si0[DW-1:0];
   assign w_y1_re = (SCALE != 0) ? w_sr1[DW:1] : w_sr1[DW-1:0];
   assign w_y1_im = (SCALE != 0) ? w_si1[DW:1] : w_si1[DW-1:0];

   assign w_unused = ^{c_in, cps_in, cms_in, w_re_sh, w_im_sh, w_sr0, w_si0, w_sr1, w_si1};

   // Data stages carry no reset; only the valid bits qualify them.
   always_ff @(posedge clk) begin
      r1_addr  <= in_addr;
      r1_x0_re <= x0_re;
      r1_x0_im <= x0_im;
      r1_a     <= x1_re;
      r1_b     <= x1_im;
      r1_c     <= c_in[TW_W-1:0];
      r1_p     <= cps_in[TW_W-1:0];
      r1_m     <= cms_in[TW_W-1:0];

      r2_addr  <= r1_addr;
      r2_x0_re <= r1_x0_re;
      r2_x0_im <= r1_x0_im;
      r2_t     <= w_c_x * w_d_x;
      r2_pr    <= w_b_x * w_m_x;
      r2_pi    <= w_a_x * w_p_x;

      r3_addr  <= r2_addr;
      r3_x0_re <= r2_x0_re;
      r3_x0_im <= r2_x0_im;
      r3_wr    <= w_re_sh[WW-1:0];
      r3_wi    <= w_im_sh[WW-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r1_vld    <= 1'b0;
         r2_vld    <= 1'b0;
         r3_vld    <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         out_addr  <= '0;
         y0_re     <= '0;
         y0_im     <= '0;
         y1_re     <= '0;
         y1_im     <= '0;
         r_cnt     <= '0;
      end else begin
         r1_vld    <= in_valid;
         r2_vld    <= r1_vld;
         r3_vld    <= r2_vld;
         out_valid <= r3_vld;
         done      <= r3_vld && (r_cnt == LAST);
         if (r3_vld) begin
            r_cnt    <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            out_addr <= r3_addr;
            y0_re    <= w_y0_re;
            y0_im    <= w_y0_im;
            y1_re    <= w_y1_re;
            y1_im    <= w_y1_im;
         end
      end
   end

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// Bench for fft_bfly_pipe: SCALE=1 and SCALE=0 instances share one stimulus stream, checked by table and scoreboard.
module tb_fft_bfly_pipe;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid;
   logic [2:0]         in_addr;
   logic signed [15:0] x0_re, x0_im, x1_re, x1_im;
   logic [15:0]        c_in, cps_in, cms_in;

   logic               o1_valid, o1_done, o0_valid, o0_done;
   logic [2:0]         o1_addr, o0_addr;
   logic signed [15:0] o1_y0_re, o1_y0_im, o1_y1_re, o1_y1_im;
   logic signed [15:0] o0_y0_re, o0_y0_im, o0_y1_re, o0_y1_im;

   always #5 clk = ~clk;

   fft_bfly_pipe #(.SCALE(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr),
      .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
      .c_in(c_in), .cps_in(cps_in), .cms_in(cms_in),
      .out_valid(o1_valid), .out_addr(o1_addr),
      .y0_re(o1_y0_re), .y0_im(o1_y0_im), .y1_re(o1_y1_re), .y1_im(o1_y1_im),
      .done(o1_done)
   );

   fft_bfly_pipe #(.SCALE(0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr),
      .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
      .c_in(c_in), .cps_in(cps_in), .cms_in(cms_in),
      .out_valid(o0_valid), .out_addr(o0_addr),
      .y0_re(o0_y0_re), .y0_im(o0_y0_im), .y1_re(o0_y1_re), .y1_im(o0_y1_im),
      .done(o0_done)
   );

   typedef struct packed {
      logic signed [15:0] y0r, y0i, y1r, y1i;
   } res_t;

   typedef struct packed {
      logic [2:0] addr;
      logic       done;
      res_t       r1;
      res_t       r0;
   } sb_t;

   typedef struct {
      int x0r, x0i, x1r, x1i;
      logic [15:0] c, p, m;
      int a0r, a0i, a1r, a1i;
      int b0r, b0i, b1r, b1i;
   } vec_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   bcnt    = 0;
   sb_t  sbq[$];
   sb_t  mon_e;
   vec_t tv[6];

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Integer reference: W*x1 via the 3-multiplier identity, floor shift, 17-bit keep, then butterfly.
   function automatic res_t model(input int x0r, input int x0i, input int x1r, input int x1i,
                                  input logic [15:0] c, input logic [15:0] p, input logic [15:0] m,
                                  input bit scale);
      logic signed [8:0]  c9, p9, m9;
      logic signed [16:0] wr17, wi17;
      longint cl, pl, ml, d, t, pr, pi, wr, wi, s0r, s0i, s1r, s1i;
      res_t r;
      c9 = c[8:0]; p9 = p[8:0]; m9 = m[8:0];
      cl = c9; pl = p9; ml = m9;
      d  = longint'(x1r) - longint'(x1i);
      t  = cl * d;
      pr = longint'(x1i) * ml;
      pi = longint'(x1r) * pl;
      wr = (t + pr) >>> 7;
      wi = (pi - t) >>> 7;
      wr17 = wr[16:0];
      wi17 = wi[16:0];
      s0r = longint'(x0r) + longint'(wr17);
      s0i = longint'(x0i) + longint'(wi17);
      s1r = longint'(x0r) - longint'(wr17);
      s1i = longint'(x0i) - longint'(wi17);
      if (scale) begin
         s0r = s0r >>> 1; s0i = s0i >>> 1; s1r = s1r >>> 1; s1i = s1i >>> 1;
      end
      r.y0r = s0r[15:0]; r.y0i = s0i[15:0]; r.y1r = s1r[15:0]; r.y1i = s1i[15:0];
      return r;
   endfunction

   function automatic vec_t mk(input int x0r, input int x0i, input int x1r, input int x1i,
                               input logic [15:0] c, input logic [15:0] p, input logic [15:0] m,
                               input int a0r, input int a0i, input int a1r, input int a1i,
                               input int b0r, input int b0i, input int b1r, input int b1i);
      vec_t v;
      v.x0r = x0r; v.x0i = x0i; v.x1r = x1r; v.x1i = x1i;
      v.c = c; v.p = p; v.m = m;
      v.a0r = a0r; v.a0i = a0i; v.a1r = a1r; v.a1i = a1i;
      v.b0r = b0r; v.b0i = b0i; v.b1r = b1r; v.b1i = b1i;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drive(input int addr, input int x0r, input int x0i, input int x1r, input int x1i,
                        input logic [15:0] c, input logic [15:0] p, input logic [15:0] m);
      sb_t e;
      in_valid = 1'b1;
      in_addr  = addr[2:0];
      x0_re = x0r[15:0]; x0_im = x0i[15:0]; x1_re = x1r[15:0]; x1_im = x1i[15:0];
      c_in = c; cps_in = p; cms_in = m;
      e.addr = addr[2:0];
      e.done = (bcnt == 7);
      e.r1   = model(x0r, x0i, x1r, x1i, c, p, m, 1'b1);
      e.r0   = model(x0r, x0i, x1r, x1i, c, p, m, 1'b0);
      bcnt   = (bcnt == 7) ? 0 : bcnt + 1;
      sbq.push_back(e);
   endtask

   task automatic drive_rand(input int addr);
      drive(addr, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
            $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
            16'($urandom), 16'($urandom), 16'($urandom));
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("valid_pair", o0_valid, o1_valid);
         if (o1_valid) begin
            if (sbq.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               mon_e = sbq.pop_front();
               chk("sb_addr", o1_addr, mon_e.addr);
               chk("sb_done", o1_done, mon_e.done);
               chk("sb_s1_y0re", o1_y0_re, mon_e.r1.y0r);
               chk("sb_s1_y0im", o1_y0_im, mon_e.r1.y0i);
               chk("sb_s1_y1re", o1_y1_re, mon_e.r1.y1r);
               chk("sb_s1_y1im", o1_y1_im, mon_e.r1.y1i);
               chk("sb_s0_y0re", o0_y0_re, mon_e.r0.y0r);
               chk("sb_s0_y0im", o0_y0_im, mon_e.r0.y0i);
               chk("sb_s0_y1re", o0_y1_re, mon_e.r0.y1r);
               chk("sb_s0_y1im", o0_y1_im, mon_e.r0.y1i);
            end
         end else begin
            chk("done_idle", o1_done, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] pat;
      int nv;
      tv[0] = mk(100, 0, 64, 0, 16'd127, 16'd127, 16'd127, 81, 0, 18, 0, 163, 0, 37, 0);
      tv[1] = mk(100, 0, 64, 0, 16'd0, 16'hFF81, 16'h007F, 50, -32, 50, 32, 100, -64, 100, 64);
      tv[2] = mk(0, 0, 0, 64, 16'd0, 16'h007F, 16'h5F81, -32, 0, 32, 0, -64, 0, 64, 0);
      tv[3] = mk(0, 100, 0, 64, 16'hAA7F, 16'd127, 16'd127, 0, 81, 0, 18, 0, 163, 0, 37);
      tv[4] = mk(-100, 0, -64, 0, 16'd127, 16'd127, 16'd127, -82, 0, -18, 0, -164, 0, -36, 0);
      tv[5] = mk(32767, 0, 32767, 0, 16'd127, 16'd127, 16'd127, 32639, 0, 128, 0, -258, 0, 256, 0);

      idle();
      in_addr = '0; x0_re = '0; x0_im = '0; x1_re = '0; x1_im = '0;
      c_in = '0; cps_in = '0; cms_in = '0;
      repeat (3) tick();
      chk("rst_valid", o1_valid, 0);
      chk("rst_done", o1_done, 0);
      chk("rst_addr", o1_addr, 0);
      chk("rst_y0re", o1_y0_re, 0);
      chk("rst_y0im", o1_y0_im, 0);
      chk("rst_y1re", o1_y1_re, 0);
      chk("rst_y1im", o1_y1_im, 0);
      chk("rst_s0_valid", o0_valid, 0);
      chk("rst_s0_y0re", o0_y0_re, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         drive(i, tv[i].x0r, tv[i].x0i, tv[i].x1r, tv[i].x1i, tv[i].c, tv[i].p, tv[i].m);
         for (int k = 0; k < 3; k++) begin
            tick();
            idle();
         end
         tick();
         chk("tbl_valid", o1_valid, 1);
         chk("tbl_addr", o1_addr, i);
         chk("tbl_s1_y0re", o1_y0_re, tv[i].a0r);
         chk("tbl_s1_y0im", o1_y0_im, tv[i].a0i);
         chk("tbl_s1_y1re", o1_y1_re, tv[i].a1r);
         chk("tbl_s1_y1im", o1_y1_im, tv[i].a1i);
         chk("tbl_s0_y0re", o0_y0_re, tv[i].b0r);
         chk("tbl_s0_y0im", o0_y0_im, tv[i].b0i);
         chk("tbl_s0_y1re", o0_y1_re, tv[i].b1r);
         chk("tbl_s0_y1im", o0_y1_im, tv[i].b1i);
         tick();
      end

      // Reset with three butterflies in flight: none may emerge.
      for (int n = 0; n < 10; n++) begin
         if (n < 3) drive_rand(n);
         else idle();
         if (n == 3) begin
            rst = 1'b1;
            sbq.delete();
            bcnt = 0;
         end
         if (n == 4) rst = 1'b0;
         tick();
         if (n >= 4) chk("midrst_valid", o1_valid, 0);
      end

      // One full pass back-to-back: done only alongside addr 7.
      for (int n = 0; n < 14; n++) begin
         tick();
         chk("stream_valid", o1_valid, (n >= 4 && n < 12) ? 1 : 0);
         if (n >= 4 && n < 12) begin
            chk("stream_addr", o1_addr, n - 4);
            chk("stream_done", o1_done, (n == 11) ? 1 : 0);
         end
         if (n < 8) drive_rand(n);
         else idle();
      end

      pat = 5'b01101;
      for (int n = 0; n < 10; n++) begin
         tick();
         chk("gap_valid", o1_valid, (n >= 4) ? int'(pat[n-4]) : 0);
         if (n < 5 && pat[n]) drive_rand(bcnt);
         else idle();
      end

      nv = 0;
      while (nv < 1000) begin
         tick();
         if ($urandom_range(0, 3) != 0) begin
            drive_rand(bcnt);
            nv++;
         end else begin
            idle();
         end
      end
      tick();
      idle();
      repeat (6) tick();
      chk("sb_empty", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
